// File: rtl/pipe_pkg.sv
// Shared types and constants for the integer pipeline.
// Operand-select encodings and the per-stage tracking record.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [2:0] SEL_RF  = 3'b001;
  localparam logic [2:0] SEL_MEM = 3'b010;
  localparam logic [2:0] SEL_WB  = 3'b100;

  typedef struct packed {
    logic                  v;
    logic [REG_AW_DEF-1:0] rd;
    logic                  rw;
    logic                  ld;
  } stage_rec_t;

  localparam stage_rec_t REC_EMPTY = '0;

  // A record only forwards if it really writes a non-zero GPR
  function automatic logic is_producer(input stage_rec_t r);
    return r.v & r.rw & (r.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// Priority compare for one EX operand.
// Youngest in-flight writer wins; x0 and unread sources use the RF.
module fwd_sel_gen
  import pipe_pkg::*;
#(
  parameter int AW = REG_AW_DEF
) (
  input  logic          use_rs,
  input  logic [AW-1:0] rs,
  input  logic          ex_prod,
  input  logic [AW-1:0] ex_rd,
  input  logic          mem_prod,
  input  logic [AW-1:0] mem_rd,
  output logic [2:0]    sel
);

  // Pick the operand source, checking the youngest producer first
  always_comb begin
    sel = SEL_RF;
    priority case (1'b1)
      (!use_rs || rs == '0):        sel = SEL_RF;
      (ex_prod && ex_rd == rs):     sel = SEL_MEM;
      (mem_prod && mem_rd == rs):   sel = SEL_WB;
      default:                      sel = SEL_RF;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard control for the 5-stage pipeline.
// Shadows EX/MEM/WB destinations and registers the EX operand selects.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  output logic [2:0]        ex_sel_a,
  output logic [2:0]        ex_sel_b,
  output logic              stall_id
);

  stage_rec_t ex_q, ex_d;
  stage_rec_t mem_q, mem_d;
  stage_rec_t wb_q, wb_d;

  logic [2:0] sel_a_q, sel_a_d;
  logic [2:0] sel_b_q, sel_b_d;

  logic       ex_prod;
  logic       mem_prod;
  logic       lu;
  logic       bubble;
  logic [2:0] gen_a;
  logic [2:0] gen_b;

  // Producer qualification of the shadow records
  always_comb begin
    ex_prod  = is_producer(ex_q);
    mem_prod = is_producer(mem_q);
  end

  // Load-use: a load in EX feeds a source the ID instruction reads
  always_comb begin
    lu = id_valid & ex_prod & ex_q.ld &
         ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
          (id_use_rs2 & (id_rs2 == ex_q.rd)));
    stall_id = lu & ~flush;
    bubble   = flush | lu | ~id_valid;
  end

  fwd_sel_gen #(
    .AW(REG_AW)
  ) u_sel_a (
    .use_rs  (id_use_rs1),
    .rs      (id_rs1),
    .ex_prod (ex_prod),
    .ex_rd   (ex_q.rd),
    .mem_prod(mem_prod),
    .mem_rd  (mem_q.rd),
    .sel     (gen_a)
  );

  fwd_sel_gen #(
    .AW(REG_AW)
  ) u_sel_b (
    .use_rs  (id_use_rs2),
    .rs      (id_rs2),
    .ex_prod (ex_prod),
    .ex_rd   (ex_q.rd),
    .mem_prod(mem_prod),
    .mem_rd  (mem_q.rd),
    .sel     (gen_b)
  );

  // Advance the shadow pipeline unless frozen
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble) begin
        ex_d    = REC_EMPTY;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
      end else begin
        ex_d.v  = 1'b1;
        ex_d.rd = id_rd;
        ex_d.rw = id_regwrite;
        ex_d.ld = id_is_load;
        sel_a_d = gen_a;
        sel_b_d = gen_b;
      end
    end
  end

  // State registers; reset wins over hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= REC_EMPTY;
      mem_q   <= REC_EMPTY;
      wb_q    <= REC_EMPTY;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign ex_sel_a = sel_a_q;
  assign ex_sel_b = sel_b_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed hazard sequences
// followed by random traffic against an in-flight history model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, hold, flush, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       id_regwrite, id_is_load;
  logic [2:0] ex_sel_a, ex_sel_b;
  logic       stall_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_is_load (id_is_load),
    .ex_sel_a   (ex_sel_a),
    .ex_sel_b   (ex_sel_b),
    .stall_id   (stall_id)
  );

  // History of instructions that entered EX: [0] now in EX, [1] in MEM
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
  } instr_t;

  instr_t hist[2];
  int     exp_a = 1;
  int     exp_b = 1;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Distance (1 = EX, 2 = MEM) of the youngest in-flight writer of r
  function automatic int writer_dist(input int r);
    if (r == 0) return 0;
    for (int d = 0; d < 2; d++)
      if (hist[d].v && hist[d].rw && hist[d].rd == r) return d + 1;
    return 0;
  endfunction

  function automatic int want_sel(input bit use_r, input int r);
    int d;
    if (!use_r) return 1;
    d = writer_dist(r);
    if (d == 1) return 2;
    if (d == 2) return 4;
    return 1;
  endfunction

  function automatic bit reads_load(input bit use_r, input int r);
    return use_r && writer_dist(r) == 1 && hist[0].ld;
  endfunction

  // One ID cycle: drive, check the stall, clock, check the selects
  task automatic cyc(input bit r, input bit h, input bit f, input bit v,
                     input int rs1, input int rs2,
                     input bit u1, input bit u2,
                     input int rd, input bit rw, input bit ld);
    bit     lu;
    int     na, nb;
    instr_t nh0, nh1;
    rst = r; hold = h; flush = f; id_valid = v;
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = 5'(rd); id_regwrite = rw; id_is_load = ld;
    #1;
    lu = v && (reads_load(u1, rs1) || reads_load(u2, rs2));
    check("stall_id", int'(stall_id), int'(lu && !f));
    nh0 = hist[0]; nh1 = hist[1]; na = exp_a; nb = exp_b;
    if (r) begin
      nh0 = '{0, 0, 0, 0}; nh1 = '{0, 0, 0, 0}; na = 1; nb = 1;
    end else if (!h) begin
      nh1 = hist[0];
      if (f || lu || !v) begin
        nh0 = '{0, 0, 0, 0}; na = 1; nb = 1;
      end else begin
        nh0 = '{1, rd, rw, ld};
        na = want_sel(u1, rs1);
        nb = want_sel(u2, rs2);
      end
    end
    @(posedge clk);
    #1;
    hist[0] = nh0; hist[1] = nh1; exp_a = na; exp_b = nb;
    check("sel_a", int'(ex_sel_a), exp_a);
    check("sel_b", int'(ex_sel_b), exp_b);
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    cyc(0, 0, 0, 1, rs1, rs2, 1, 1, rd, 1, 0);
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    hist[0] = '{0, 0, 0, 0};
    hist[1] = '{0, 0, 0, 0};
    rst = 1; hold = 1; flush = 0; id_valid = 1;
    id_rs1 = 5; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = 5; id_regwrite = 1; id_is_load = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel_a", int'(ex_sel_a), 1);
    check("rst_sel_b", int'(ex_sel_b), 1);
    check("rst_stall", int'(stall_id), 0);

    // back-to-back ALU dependency
    alu(5, 1, 2);
    alu(6, 5, 1);
    check("b2b_a", int'(ex_sel_a), 2);
    check("b2b_b", int'(ex_sel_b), 1);

    // distance two
    alu(5, 1, 2);
    nop();
    alu(7, 5, 5);
    check("d2_a", int'(ex_sel_a), 4);
    check("d2_b", int'(ex_sel_b), 4);

    // both EX and MEM write x5: youngest wins
    alu(5, 1, 2);
    alu(5, 3, 4);
    alu(9, 5, 0);
    check("young_a", int'(ex_sel_a), 2);

    // load-use
    cyc(0, 0, 0, 1, 1, 0, 1, 0, 8, 1, 1);
    cyc(0, 0, 0, 1, 8, 2, 1, 1, 9, 1, 0);
    check("lu_bub_a", int'(ex_sel_a), 1);
    cyc(0, 0, 0, 1, 8, 2, 1, 1, 9, 1, 0);
    check("lu_fwd_a", int'(ex_sel_a), 4);

    // x0 producer, x0 consumer
    alu(0, 1, 2);
    alu(3, 0, 0);
    check("x0_a", int'(ex_sel_a), 1);

    // unused rs2 matching a producer
    alu(12, 1, 2);
    cyc(0, 0, 0, 1, 1, 12, 1, 0, 13, 1, 0);
    check("nouse_b", int'(ex_sel_b), 1);

    // flush during load-use
    cyc(0, 0, 0, 1, 1, 0, 1, 0, 8, 1, 1);
    cyc(0, 0, 1, 1, 8, 8, 1, 1, 9, 1, 0);
    check("flush_a", int'(ex_sel_a), 1);

    // hold for three cycles, then release
    alu(5, 1, 2);
    alu(6, 5, 1);
    repeat (3) cyc(0, 1, 0, 1, 5, 6, 1, 1, 10, 1, 0);
    check("hold_a", int'(ex_sel_a), 2);
    cyc(0, 0, 0, 1, 5, 6, 1, 1, 10, 1, 0);
    check("rel_a", int'(ex_sel_a), 4);
    check("rel_b", int'(ex_sel_b), 2);

    // reset with hold and pending load-use
    cyc(0, 0, 0, 1, 1, 0, 1, 0, 8, 1, 1);
    cyc(1, 1, 0, 1, 8, 8, 1, 1, 9, 1, 0);
    check("mrst_a", int'(ex_sel_a), 1);
    check("mrst_stall", int'(stall_id), 0);
    alu(9, 8, 8);
    check("mrst_nofwd", int'(ex_sel_a), 1);

    // random traffic over a narrow register range to provoke hits
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 7) != 0,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
